tribus_arbiter: RTL and testbench

TRIBUS_ARBITER -- requirements
Module: tribus_arbiter

---
 rtl/tribus_arbiter.sv | 92 +++++++++
 tb/tb_tribus_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/tribus_arbiter.sv
// tribus_arbiter: round-robin owner select for a shared resolved bus,
// with a hold limit and a released-bus turnaround between owners.
module tribus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int HOLD_MAX = 8,
    parameter int TURN_CYC = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         done,
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         drv_en,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic                     turn
);
    localparam int W = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

    state_t           state;
    logic [W-1:0]     last_owner;
    logic [W-1:0]     win;
    logic [W-1:0]     idx;
    logic [7:0]       hold;
    logic [2:0]       tcnt;
    logic [N_REQ-1:0] win_oh;
    logic             rel;

    // Scan from the highest offset down so the nearest requester after last_owner wins.
    always_comb begin
        win = last_owner;
        idx = last_owner;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = W'((int'(last_owner) + i) % N_REQ);
            if (req[idx]) win = idx;
        end
    end

    assign win_oh = N_REQ'(1) << win;
    assign rel    = !req[owner] || done[owner] || hold == 8'(HOLD_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            drv_en     <= '0;
            owner      <= '0;
            busy       <= 1'b0;
            turn       <= 1'b0;
            hold       <= '0;
            tcnt       <= '0;
            last_owner <= W'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: if (|req) begin
                    state  <= OWN;
                    owner  <= win;
                    grant  <= win_oh;
                    drv_en <= win_oh;
                    busy   <= 1'b1;
                    hold   <= 8'd1;
                end
                OWN: if (rel) begin
                    state      <= TURN;
                    last_owner <= owner;
                    grant      <= '0;
                    drv_en     <= '0;
                    busy       <= 1'b0;
                    turn       <= 1'b1;
                    tcnt       <= 3'd1;
                end else begin
                    hold <= hold + 8'd1;
                end
                TURN: if (tcnt == 3'(TURN_CYC)) begin
                    state <= IDLE;
                    turn  <= 1'b0;
                end else begin
                    tcnt <= tcnt + 3'd1;
                end
                default: begin
                    state  <= IDLE;
                    grant  <= '0;
                    drv_en <= '0;
                    busy   <= 1'b0;
                    turn   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tribus_arbiter.sv
// tb_tribus_arbiter: directed checks of the arbiter with default timing
// and a second instance using a three-cycle turnaround.
module tb_tribus_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_a, done_a, grant_a, drv_a;
    logic [3:0] req_b, done_b, grant_b, drv_b;
    logic [1:0] owner_a, owner_b;
    logic       busy_a, turn_a, busy_b, turn_b;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    tribus_arbiter #(.N_REQ(4), .HOLD_MAX(8), .TURN_CYC(1)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .done(done_a),
        .grant(grant_a), .drv_en(drv_a), .owner(owner_a), .busy(busy_a), .turn(turn_a)
    );

    tribus_arbiter #(.N_REQ(4), .HOLD_MAX(8), .TURN_CYC(3)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .done(done_b),
        .grant(grant_b), .drv_en(drv_b), .owner(owner_b), .busy(busy_b), .turn(turn_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            assert ($onehot0(grant_a) && $onehot0(grant_b) && drv_a === grant_a && drv_b === grant_b) else begin
                errors++;
                $error("FAIL onehot grant_a=%b drv_a=%b grant_b=%b drv_b=%b expected one-hot-or-zero and drv_en==grant",
                       grant_a, drv_a, grant_b, drv_b);
            end
        end
    end

    initial begin
        rst = 1'b1; req_a = '0; done_a = '0; req_b = '0; done_b = '0;
        #3;
        chk("rst_grant", 32'(grant_a), 32'h0);
        chk("rst_drv", 32'(drv_a), 32'h0);
        chk("rst_busy_turn", {30'd0, busy_a, turn_a}, 32'h0);
        chk("rst_owner", 32'(owner_a), 32'h0);
        tick; tick;
        rst = 1'b0;
        // round-robin from reset: 1 then 3, 8-cycle hold, one TURN cycle
        req_a = 4'b1010;
        tick;
        chk("rr_g1", 32'(grant_a), 32'h2);
        chk("rr_o1", 32'(owner_a), 32'h1);
        chk("rr_busy", 32'(busy_a), 32'h1);
        repeat (7) tick;
        chk("rr_hold8", 32'(grant_a), 32'h2);
        tick;
        chk("rr_turn", {30'd0, busy_a, turn_a}, 32'h1);
        chk("rr_turn_drv", 32'(drv_a), 32'h0);
        tick;
        chk("rr_idle", {30'd0, busy_a, turn_a}, 32'h0);
        tick;
        chk("rr_g3", 32'(grant_a), 32'h8);
        chk("rr_o3", 32'(owner_a), 32'h3);
        req_a = 4'b0000;
        tick;
        chk("drop_turn", 32'(turn_a), 32'h1);
        tick;
        // single requester with done in third OWN cycle
        req_a = 4'b0001;
        tick;
        chk("done_c1", 32'(grant_a), 32'h1);
        tick;
        tick;
        chk("done_c3", 32'(grant_a), 32'h1);
        done_a = 4'b0001;
        tick;
        done_a = 4'b0000;
        chk("done_turn", {30'd0, busy_a, turn_a}, 32'h1);
        chk("done_turn_drv", 32'(drv_a), 32'h0);
        tick;
        chk("done_idle_drv", 32'(drv_a), 32'h0);
        chk("done_idle", {30'd0, busy_a, turn_a}, 32'h0);
        tick;
        chk("done_regrant", 32'(grant_a), 32'h1);
        req_a = 4'b0000;
        tick; tick;
        // all four requesting: fair rotation after an async reset pulse
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        req_a = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("all_grant", 32'(grant_a), 32'(1 << (k % 4)));
            chk("all_owner", 32'(owner_a), 32'(k % 4));
            for (int c = 2; c <= 8; c++) begin
                tick;
                chk("all_hold", 32'(grant_a), 32'(1 << (k % 4)));
            end
            tick;
            chk("all_turn", {28'd0, grant_a}, 32'h0);
            chk("all_turn_flag", 32'(turn_a), 32'h1);
            if (k == 4) req_a = 4'b0000;
            tick;
            chk("all_idle", {30'd0, busy_a, turn_a}, 32'h0);
        end
        // async reset while requester 2 owns the bus
        req_a = 4'b0100;
        tick;
        chk("ar_grant", 32'(grant_a), 32'h4);
        #2 rst = 1'b1;
        #1;
        chk("ar_grant0", 32'(grant_a), 32'h0);
        chk("ar_drv0", 32'(drv_a), 32'h0);
        chk("ar_busy0", 32'(busy_a), 32'h0);
        #1 rst = 1'b0;
        tick;
        chk("ar_regrant", 32'(grant_a), 32'h4);
        chk("ar_owner", 32'(owner_a), 32'h2);
        // non-owner req/done toggling must not disturb owner 2
        req_a = 4'b0110; done_a = 4'b0010;
        tick;
        chk("nonown_1", 32'(grant_a), 32'h4);
        req_a = 4'b0100; done_a = 4'b0000;
        tick;
        chk("nonown_2", 32'(grant_a), 32'h4);
        req_a = 4'b0110; done_a = 4'b0010;
        tick;
        chk("nonown_3", 32'(grant_a), 32'h4);
        req_a = 4'b0010; done_a = 4'b0110;
        tick;
        done_a = 4'b0000;
        chk("own_drop_turn", {30'd0, busy_a, turn_a}, 32'h1);
        tick;
        chk("own_drop_idle", {30'd0, busy_a, turn_a}, 32'h0);
        tick;
        chk("own_drop_next", 32'(grant_a), 32'h2);
        chk("own_drop_owner", 32'(owner_a), 32'h1);
        req_a = 4'b0000;
        tick; tick;
        // three-cycle turnaround instance
        req_b = 4'b0011;
        tick;
        chk("t3_g0", 32'(grant_b), 32'h1);
        repeat (7) tick;
        chk("t3_hold8", 32'(grant_b), 32'h1);
        for (int t = 0; t < 3; t++) begin
            tick;
            chk("t3_turn", 32'(turn_b), 32'h1);
            chk("t3_drv", 32'(drv_b), 32'h0);
        end
        tick;
        chk("t3_idle", {30'd0, busy_b, turn_b}, 32'h0);
        tick;
        chk("t3_g1", 32'(grant_b), 32'h2);
        chk("t3_o1", 32'(owner_b), 32'h1);
        req_b = 4'b0000;
        tick; tick; tick; tick; tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
